// File: rtl/mips_mdu_pkg.sv
// Shared MDU op codes, sequencer state encoding and op classification helpers.
package mips_mdu_pkg;

  localparam int unsigned MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 4'd0,
    MDU_MULTU = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_MTHI  = 4'd4,
    MDU_MTLO  = 4'd5,
    MDU_MADD  = 4'd6,
    MDU_MADDU = 4'd7,
    MDU_MSUB  = 4'd8,
    MDU_MSUBU = 4'd9
  } mdu_op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mdu_state_e;

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) ||
           (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
  endfunction

endpackage

// File: rtl/mips_mdu_datapath.sv
// Combinational MDU arithmetic: produces the new {hi,lo} from latched operands.
module mdu_datapath
  import mips_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [MDU_OP_W-1:0]   op,
  input  logic [2*WIDTH-1:0]    hilo,
  output logic [2*WIDTH-1:0]    result
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   safe_b;
  logic [WIDTH-1:0]   safe_mag_b;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   q_u;
  logic [WIDTH-1:0]   r_u;

  // Products and quotients; signed divide works on magnitudes so that
  // most-negative / -1 wraps cleanly to most-negative with remainder 0.
  always_comb begin
    prod_s     = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    neg_a      = a[WIDTH-1];
    neg_b      = b[WIDTH-1];
    mag_a      = neg_a ? (~a + WIDTH'(1)) : a;
    mag_b      = neg_b ? (~b + WIDTH'(1)) : b;
    // Zero divisors never commit; substitute 1 to keep the divider defined.
    safe_b     = (b == '0) ? WIDTH'(1) : b;
    safe_mag_b = (mag_b == '0) ? WIDTH'(1) : mag_b;
    q_u        = a / safe_b;
    r_u        = a % safe_b;
    q_mag      = mag_a / safe_mag_b;
    r_mag      = mag_a % safe_mag_b;
    q_s        = (neg_a ^ neg_b) ? (~q_mag + WIDTH'(1)) : q_mag;
    r_s        = neg_a ? (~r_mag + WIDTH'(1)) : r_mag;
  end

  // Select the new {hi,lo} for the latched op.
  always_comb begin
    result = hilo;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = {r_s, q_s};
      MDU_DIVU:  result = {r_u, q_u};
      MDU_MADD:  result = hilo + prod_s;
      MDU_MADDU: result = hilo + prod_u;
      MDU_MSUB:  result = hilo - prod_s;
      MDU_MSUBU: result = hilo - prod_u;
      default:   result = hilo;
    endcase
  end

endmodule

// File: rtl/mips_mdu.sv
// Multiply/divide unit: owns HI/LO, sequences fixed-latency multi-cycle ops.
module mips_mdu
  import mips_mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    rs_val,
  input  logic [WIDTH-1:0]    rt_val,
  input  logic                req,
  output logic                busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  mdu_state_e          state;
  mdu_state_e          state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [MDU_OP_W-1:0] op_q;
  logic                accept;
  logic                launch;
  logic                done;
  logic                wr_en;
  logic [2*WIDTH-1:0]  result;

  assign accept = start && !req && !busy;
  assign launch = accept && (is_mul_op(op) || is_div_op(op));
  // A divide by zero runs its full latency but leaves HI/LO untouched.
  assign wr_en  = !(is_div_op(op_q) && (b_q == '0));

  mdu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .hilo   ({hi, lo}),
    .result (result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: launch into RUN, leave on the final counted cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_W'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_RUN) && (cnt == CNT_W'(1));
  end

  // Operand latches and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (launch) begin
      a_q  <= rs_val;
      b_q  <= rt_val;
      op_q <= op;
      cnt  <= is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (busy) begin
      cnt  <= cnt - CNT_W'(1);
    end
  end

  // HI/LO: commit at completion, or direct move-to on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      if (wr_en) {hi, lo} <= result;
    end else if (accept && (op == MDU_MTHI)) begin
      hi <= rs_val;
    end else if (accept && (op == MDU_MTLO)) begin
      lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_mips_mdu.sv
// Self-checking bench for mips_mdu against a 64-bit arithmetic reference model.
module tb_mips_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  mips_mdu #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .req    (req),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned op_cycles(input logic [3:0] o);
    if (o inside {4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9}) return 5;
    if (o inside {4'd2, 4'd3}) return 10;
    return 0;
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural {hi,lo} pair.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] acc;
    logic [63:0] ps;
    logic [63:0] pu;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = 64'(sa * sb);
    pu  = {32'b0, a} * {32'b0, b};
    acc = {mhi, mlo};
    case (o)
      4'd0: acc = ps;
      4'd1: acc = pu;
      4'd2: if (b != 0) begin
        q   = sa / sb;
        r   = sa % sb;
        acc = {r[31:0], q[31:0]};
      end
      4'd3: if (b != 0) acc = {a % b, a / b};
      4'd4: acc[63:32] = a;
      4'd5: acc[31:0] = a;
      4'd6: acc = acc + ps;
      4'd7: acc = acc + pu;
      4'd8: acc = acc - ps;
      4'd9: acc = acc - pu;
      default: ;
    endcase
    {mhi, mlo} = acc;
  endtask

  // Issue one op from idle; track busy cycle by cycle and HI/LO at completion.
  // With inject set, a second start (MTHI) is raised while the op is in flight.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic r, input logic inject);
    int unsigned n;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = mhi;
    old_lo = mlo;
    n = r ? 0 : op_cycles(o);
    if (!r) model_apply(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; req = r;
    @(negedge clk);
    start = 1'b0; req = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      check({tag, " busy"}, {63'b0, busy}, 64'd1);
      check({tag, " hi held"}, {32'b0, hi}, {32'b0, old_hi});
      check({tag, " lo held"}, {32'b0, lo}, {32'b0, old_lo});
      if (inject && k == 1) begin
        start = 1'b1; op = 4'd4; rs_val = 32'hDEADBEEF;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, " busy done"}, {63'b0, busy}, 64'd0);
    check({tag, " hi"}, {32'b0, hi}, {32'b0, mhi});
    check({tag, " lo"}, {32'b0, lo}, {32'b0, mlo});
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rr;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset hi", {32'b0, hi}, 64'd0);
    check("reset lo", {32'b0, lo}, 64'd0);

    // 1. MULT -2 * 3
    run_op("mult", 4'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check("mult hi const", {32'b0, hi}, 64'h0000_0000_FFFF_FFFF);
    check("mult lo const", {32'b0, lo}, 64'h0000_0000_FFFF_FFFA);

    // 2. MULTU max * max
    run_op("multu", 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("multu hi const", {32'b0, hi}, 64'h0000_0000_FFFF_FFFE);
    check("multu lo const", {32'b0, lo}, 64'h0000_0000_0000_0001);

    // 3. DIV -7 / 2, then DIVU by zero leaves HI/LO alone
    run_op("div", 4'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("div lo const", {32'b0, lo}, 64'h0000_0000_FFFF_FFFD);
    check("div hi const", {32'b0, hi}, 64'h0000_0000_FFFF_FFFF);
    run_op("divu0", 4'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    check("divu0 lo const", {32'b0, lo}, 64'h0000_0000_FFFF_FFFD);
    run_op("div0", 4'd2, 32'd9, 32'd0, 1'b0, 1'b0);

    // Most-negative / -1 wraps without trapping
    run_op("divmin", 4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("divmin lo const", {32'b0, lo}, 64'h0000_0000_8000_0000);
    check("divmin hi const", {32'b0, hi}, 64'd0);

    // 4. MTHI/MTLO then MADD; MSUBU underflow from zero
    run_op("mthi", 4'd4, 32'h12345678, 32'd0, 1'b0, 1'b0);
    run_op("mtlo", 4'd5, 32'h00000010, 32'd0, 1'b0, 1'b0);
    run_op("madd", 4'd6, 32'd2, 32'd3, 1'b0, 1'b0);
    check("madd hi const", {32'b0, hi}, 64'h0000_0000_1234_5678);
    check("madd lo const", {32'b0, lo}, 64'h0000_0000_0000_0016);
    run_op("mthi0", 4'd4, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op("mtlo0", 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op("msubu", 4'd9, 32'd1, 32'd1, 1'b0, 1'b0);
    check("msubu hi const", {32'b0, hi}, 64'h0000_0000_FFFF_FFFF);
    check("msubu lo const", {32'b0, lo}, 64'h0000_0000_FFFF_FFFF);

    // 5. start suppressed by req; start while busy ignored
    run_op("req mult", 4'd0, 32'd5, 32'd5, 1'b1, 1'b0);
    run_op("req mthi", 4'd4, 32'hAAAA5555, 32'd0, 1'b1, 1'b0);
    run_op("undef op", 4'd13, 32'd5, 32'd5, 1'b0, 1'b0);
    run_op("busy start", 4'd0, 32'h00001234, 32'h00000010, 1'b0, 1'b1);
    check("busy start hi const", {32'b0, hi}, 64'd0);
    check("busy start lo const", {32'b0, lo}, 64'h0000_0000_0001_2340);

    // 6. Reset on the third RUN cycle aborts without a late write
    @(negedge clk);
    start = 1'b1; op = 4'd1; rs_val = 32'h0000FFFF; rt_val = 32'h0000FFFF;
    @(negedge clk);
    start = 1'b0;
    check("abort busy run", {63'b0, busy}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mhi = '0;
    mlo = '0;
    check("abort busy", {63'b0, busy}, 64'd0);
    check("abort hi", {32'b0, hi}, 64'd0);
    check("abort lo", {32'b0, lo}, 64'd0);
    repeat (8) @(negedge clk);
    check("abort late busy", {63'b0, busy}, 64'd0);
    check("abort late hi", {32'b0, hi}, 64'd0);
    check("abort late lo", {32'b0, lo}, 64'd0);

    // Randomized ops, including undefined codes, zero divisors and req
    for (int unsigned i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb % 32'd17;
      rr = ($urandom_range(0, 5) == 0);
      run_op("rand", ro, ra, rb, rr, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mdu.md
Name: mips_mdu

Overview:
- Parametrised multiply/divide unit for the P7 pipeline; sits in the E stage beside the ALU.
- Owns the architectural HI/LO registers and executes mult, multu, div, divu, madd, maddu, msub and msubu.
- Models a fixed multi-cycle latency with a busy flag so the hazard unit can stall mfhi/mflo and further MDU instructions.
- Supports exception flush: a start raised in the same cycle as a pending interrupt or exception is suppressed.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- MULT_CYCLES, 5: busy cycles for multiply-class ops (≥1).
- DIV_CYCLES, 10: busy cycles for divide ops (≥1).
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  E-stage instruction is an MDU op (decoded externally)
- op  in  4  operation code, shared constants
- rs_val  in  WIDTH  forwarded rs operand
- rt_val  in  WIDTH  forwarded rt operand
- req  in  1  exception/interrupt taken this cycle; suppresses start
- busy  out  1  registered; high while an operation is in flight
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

Behaviour:
- Reset (synchronous, active-high): busy=0, hi=0, lo=0, counter=0, all operand/result latches cleared. Reset mid-operation aborts it; HI/LO are not written.
- Accept: start && !req && !busy.
  - Multi-cycle ops latch rs_val, rt_val and op, and load the counter with MULT_CYCLES or DIV_CYCLES.
  - busy rises the next cycle.
- MTHI/MTLO: single-cycle.
  - On accept, hi (or lo) <= rs_val at that edge; busy stays 0.
- States:
  - IDLE (busy=0): on an accepted multi-cycle op, go to RUN.
  - RUN (busy=1): counter decrements every cycle.
  - At the edge where counter==1, write HI/LO with the result, go to IDLE; busy falls the same edge.
  - Total: an op accepted at edge T has results visible and busy=0 after edge T+N, where N is the op's cycle count.
- start while busy: ignored (hazard unit guarantees this does not occur; the bench must still check HI/LO are unaffected).
- req with start: no state change. req during RUN: no effect, because the in-flight op is older and has committed.
- Arithmetic, with product P of width 2·WIDTH and {hi,lo} the concatenation sampled at accept:
  - MULT: P = signed product; hi=P[2W-1:W], lo=P[W-1:0].
  - MULTU: P = unsigned product.
  - MADD / MADDU: {hi,lo} <= {hi,lo} + P (signed / unsigned P); wraps modulo 2^(2W).
  - MSUB / MSUBU: {hi,lo} <= {hi,lo} − P; wraps modulo 2^(2W).
  - DIV: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (rt_val==0, DIV or DIVU): still busy for DIV_CYCLES; HI and LO remain unchanged.
- DIV with most-negative dividend and rt=−1: lo=most-negative value, hi=0; no trap.
- Undefined op codes with start: treated as no-op; busy stays 0.
- hi and lo are driven directly from registers; there is no combinational bypass of in-flight results.

Decomposition:
- Shared constants file: op codes MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5, MDU_MADD=6, MDU_MADDU=7, MDU_MSUB=8, MDU_MSUBU=9.
- The decoder exports an md_start flag and an mdu_op field using these constants.
- One combinational sub-module, mdu_datapath: computes the 2·WIDTH result from latched operands, op and the old {hi,lo}.
- The sequencing FSM, counter and HI/LO registers stay in mips_mdu.

Test Plan:
1. Reset then MULT rs=0xFFFFFFFE (−2), rt=3 → busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
2. MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
3. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles; then DIVU 7/0 → hi/lo unchanged, busy still 10 cycles.
4. MTHI 0x12345678 then MADD 2×3 → hi/lo={0x12345678, old lo+6}; MSUBU from {0,0} by 1×1 → hi=lo=0xFFFFFFFF.
5. start with req=1 → busy stays 0, hi/lo unchanged; start with busy=1 → ignored, original result intact.
6. Reset asserted on the 3rd RUN cycle of MULT → busy=0, hi=lo=0 the next cycle, and no late write occurs.
